// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store memory initiator.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } lsu_state_t;

    // Access size in bytes; illegal codes report 4 and are rejected elsewhere.
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        unique case (funct3)
            F3_B, F3_BU: access_size = 3'd1;
            F3_H, F3_HU: access_size = 3'd2;
            default:     access_size = 3'd4;
        endcase
    endfunction

    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
        if (we) begin
            funct3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end else begin
            funct3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                           (funct3 == F3_BU) || (funct3 == F3_HU);
        end
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] funct3);
        unique case (funct3)
            F3_B:    store_mask = 4'b0001;
            F3_H:    store_mask = 4'b0011;
            F3_W:    store_mask = 4'b1111;
            default: store_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_access_if.sv
// Request/response and memory-port bundle; slave is the LSU, master is its environment.
interface lsu_mem_access_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_fault;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_write_data;
    logic              mem_write_enable;
    logic [3:0]        mem_write_mask;
    logic [31:0]       mem_read_data;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  mem_address, mem_write_data, mem_write_enable, mem_write_mask
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output mem_address, mem_write_data, mem_write_enable, mem_write_mask
    );
endinterface

// File: rtl/load_extend.sv
// Selects the low byte/halfword of a loaded word and sign- or zero-extends it.
module load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] result
);

    always_comb begin
        result = raw;
        unique case (funct3)
            F3_B:    result = {{24{raw[7]}}, raw[7:0]};
            F3_H:    result = {{16{raw[15]}}, raw[15:0]};
            F3_BU:   result = {24'h0, raw[7:0]};
            F3_HU:   result = {16'h0, raw[15:0]};
            default: result = raw;
        endcase
    end

endmodule

// File: rtl/lsu_mem_access.sv
// Load/store initiator: one request at a time, IDLE -> ACCESS -> RESP, registered outputs.
// Optional misalignment trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_mem_access
    import lsu_pkg::*;
#(
    parameter int unsigned DMEM_BYTES = 4096,
    parameter int unsigned ADDR_W     = 32
) (
    input logic               clk,
    input logic               rst_n,
    lsu_mem_access_if.slave   bus
);

    lsu_state_t        state;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic              fault_q;
    logic              resp_valid_q;
    logic [31:0]       resp_rdata_q;
    logic              resp_fault_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic [31:0]       mem_write_data_q;
    logic              mem_write_enable_q;
    logic [3:0]        mem_write_mask_q;

    logic [2:0]        req_size;
    logic [ADDR_W:0]   req_last_byte;
    logic              req_misaligned;
    logic              req_fault;
    logic [31:0]       load_ext;

    // Decode the incoming request so the ACCESS-cycle outputs can be registered at accept.
    always_comb begin
        req_size      = access_size(bus.req_funct3);
        // One extra bit so an access near the top of the address space cannot wrap.
        req_last_byte = {1'b0, bus.req_addr} + (ADDR_W + 1)'(req_size) - (ADDR_W + 1)'(1);
`ifdef LSU_MISALIGN_TRAP_EN
        req_misaligned = ((req_size == 3'd2) && bus.req_addr[0]) ||
                         ((req_size == 3'd4) && (bus.req_addr[1:0] != 2'b00));
`else
        req_misaligned = 1'b0;
`endif
        req_fault = !funct3_legal(bus.req_we, bus.req_funct3) ||
                    (req_last_byte >= (ADDR_W + 1)'(DMEM_BYTES)) ||
                    req_misaligned;
    end

    load_extend u_load_extend (
        .funct3 (funct3_q),
        .raw    (bus.mem_read_data),
        .result (load_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            we_q               <= 1'b0;
            funct3_q           <= 3'b000;
            fault_q            <= 1'b0;
            resp_valid_q       <= 1'b0;
            resp_rdata_q       <= 32'h0;
            resp_fault_q       <= 1'b0;
            mem_address_q      <= '0;
            mem_write_data_q   <= 32'h0;
            mem_write_enable_q <= 1'b0;
            mem_write_mask_q   <= 4'b0000;
        end else begin
            unique case (state)
                IDLE, RESP: begin
                    resp_valid_q <= 1'b0;
                    if (bus.req_valid) begin
                        we_q               <= bus.req_we;
                        funct3_q           <= bus.req_funct3;
                        fault_q            <= req_fault;
                        mem_address_q      <= bus.req_addr;
                        mem_write_data_q   <= bus.req_wdata;
                        mem_write_enable_q <= bus.req_we && !req_fault;
                        mem_write_mask_q   <= (bus.req_we && !req_fault) ?
                                              store_mask(bus.req_funct3) : 4'b0000;
                        state              <= ACCESS;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    resp_valid_q       <= 1'b1;
                    resp_fault_q       <= fault_q;
                    resp_rdata_q       <= (we_q || fault_q) ? 32'h0 : load_ext;
                    mem_address_q      <= '0;
                    mem_write_data_q   <= 32'h0;
                    mem_write_enable_q <= 1'b0;
                    mem_write_mask_q   <= 4'b0000;
                    state              <= RESP;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready        = (state != ACCESS);
    assign bus.resp_valid       = resp_valid_q;
    assign bus.resp_rdata       = resp_rdata_q;
    assign bus.resp_fault       = resp_fault_q;
    assign bus.mem_address      = mem_address_q;
    assign bus.mem_write_data   = mem_write_data_q;
    assign bus.mem_write_enable = mem_write_enable_q;
    assign bus.mem_write_mask   = mem_write_mask_q;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed bench for lsu_mem_access with a byte-lane memory model (sync write, comb read).
module tb_lsu_mem_access;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   we_cycles = 0;

    logic [7:0]  mem [4096];
    logic [31:0] rd_word;

    always #5 clk = ~clk;

    lsu_mem_access_if #(.ADDR_W(32)) bus ();

    lsu_mem_access #(
        .DMEM_BYTES (4096),
        .ADDR_W     (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(posedge clk) begin
        if (bus.mem_write_enable) begin
            we_cycles <= we_cycles + 1;
            for (int i = 0; i < 4; i++) begin
                if (bus.mem_write_mask[i]) begin
                    mem[12'(bus.mem_address[11:0] + 12'(i))] <= bus.mem_write_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_word = 32'h0;
        for (int i = 0; i < 4; i++) begin
            rd_word[8*i +: 8] = mem[12'(bus.mem_address[11:0] + 12'(i))];
        end
    end
    assign bus.mem_read_data = rd_word;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic access(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_fault,
                          input logic [3:0] exp_mask);
        int w0;
        check({tag, " ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        w0 = we_cycles;
        check({tag, " acc_ready"}, 32'(bus.req_ready), 32'd0);
        check({tag, " addr"}, bus.mem_address, addr);
        check({tag, " we"}, 32'(bus.mem_write_enable), 32'(exp_mask != 4'b0000));
        check({tag, " mask"}, 32'(bus.mem_write_mask), 32'(exp_mask));
        check({tag, " early_resp"}, 32'(bus.resp_valid), 32'd0);
        @(posedge clk);
        #1;
        check({tag, " resp_valid"}, 32'(bus.resp_valid), 32'd1);
        check({tag, " rdata"}, bus.resp_rdata, exp_rdata);
        check({tag, " fault"}, 32'(bus.resp_fault), 32'(exp_fault));
        check({tag, " we_pulses"}, 32'(we_cycles - w0), 32'(exp_mask != 4'b0000));
        check({tag, " we_off"}, 32'(bus.mem_write_enable), 32'd0);
        @(posedge clk);
        #1;
        check({tag, " resp_pulse"}, 32'(bus.resp_valid), 32'd0);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        #3;
        check("rst ready", 32'(bus.req_ready), 32'd1);
        check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst rdata", bus.resp_rdata, 32'h0);
        check("rst fault", 32'(bus.resp_fault), 32'd0);
        check("rst addr", bus.mem_address, 32'h0);
        check("rst wdata", bus.mem_write_data, 32'h0);
        check("rst we", 32'(bus.mem_write_enable), 32'd0);
        check("rst mask", 32'(bus.mem_write_mask), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        access("SW10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 4'b1111);
        access("LW10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 4'b0000);

        access("SW20", 1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0, 1'b0, 4'b1111);
        access("SB20", 1'b1, 3'b000, 32'h20, 32'h000000F0, 32'h0, 1'b0, 4'b0001);
        access("LB20", 1'b0, 3'b000, 32'h20, 32'h0, 32'hFFFFFFF0, 1'b0, 4'b0000);
        access("LBU20", 1'b0, 3'b100, 32'h20, 32'h0, 32'h000000F0, 1'b0, 4'b0000);
        access("LW20", 1'b0, 3'b010, 32'h20, 32'h0, 32'h112233F0, 1'b0, 4'b0000);

        access("SW40", 1'b1, 3'b010, 32'h40, 32'h77668001, 32'h0, 1'b0, 4'b1111);
        access("SW44", 1'b1, 3'b010, 32'h44, 32'hA1B2C3D4, 32'h0, 1'b0, 4'b1111);
        access("LH40", 1'b0, 3'b001, 32'h40, 32'h0, 32'hFFFF8001, 1'b0, 4'b0000);
        access("LHU40", 1'b0, 3'b101, 32'h40, 32'h0, 32'h00008001, 1'b0, 4'b0000);

        access("SWFFC", 1'b1, 3'b010, 32'hFFC, 32'hCAFEF00D, 32'h0, 1'b0, 4'b1111);
        access("SWFFE", 1'b1, 3'b010, 32'hFFE, 32'h99999999, 32'h0, 1'b1, 4'b0000);
        access("LWFFC", 1'b0, 3'b010, 32'hFFC, 32'h0, 32'hCAFEF00D, 1'b0, 4'b0000);
        access("LWtop", 1'b0, 3'b010, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 4'b0000);
        access("Lf3_011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 4'b0000);
        access("Sf3_100", 1'b1, 3'b100, 32'h10, 32'h55555555, 32'h0, 1'b1, 4'b0000);
        access("LWafter", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 4'b0000);
        access("SBFFF", 1'b1, 3'b000, 32'hFFF, 32'h0000005A, 32'h0, 1'b0, 4'b0001);
        access("LBUFFF", 1'b0, 3'b100, 32'hFFF, 32'h0, 32'h0000005A, 1'b0, 4'b0000);
        access("LHFFF", 1'b0, 3'b001, 32'hFFF, 32'h0, 32'h0, 1'b1, 4'b0000);

`ifdef LSU_MISALIGN_TRAP_EN
        access("LW41", 1'b0, 3'b010, 32'h41, 32'h0, 32'h0, 1'b1, 4'b0000);
        access("LH41", 1'b0, 3'b001, 32'h41, 32'h0, 32'h0, 1'b1, 4'b0000);
`else
        access("LW41", 1'b0, 3'b010, 32'h41, 32'h0, 32'hD4776680, 1'b0, 4'b0000);
        access("LH41", 1'b0, 3'b001, 32'h41, 32'h0, 32'h00006680, 1'b0, 4'b0000);
`endif

        // Held request: accepted in IDLE and again in RESP, never in ACCESS.
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h10;
        @(posedge clk);
        #1;
        check("b2b e1 ready", 32'(bus.req_ready), 32'd0);
        check("b2b e1 resp", 32'(bus.resp_valid), 32'd0);
        @(posedge clk);
        #1;
        check("b2b e2 ready", 32'(bus.req_ready), 32'd1);
        check("b2b e2 resp", 32'(bus.resp_valid), 32'd1);
        check("b2b e2 rdata", bus.resp_rdata, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        check("b2b e3 ready", 32'(bus.req_ready), 32'd0);
        check("b2b e3 resp", 32'(bus.resp_valid), 32'd0);
        check("b2b e3 addr", bus.mem_address, 32'h10);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("b2b e4 resp", 32'(bus.resp_valid), 32'd1);
        check("b2b e4 rdata", bus.resp_rdata, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        check("b2b e5 ready", 32'(bus.req_ready), 32'd1);
        check("b2b e5 resp", 32'(bus.resp_valid), 32'd0);
        check("b2b e5 addr", bus.mem_address, 32'h0);

        // Reset during a store ACCESS must suppress the write and the response.
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h10;
        bus.req_wdata  = 32'h12345678;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("rstmid we_on", 32'(bus.mem_write_enable), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid we_drop", 32'(bus.mem_write_enable), 32'd0);
        check("rstmid ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        check("rstmid no_resp", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid idle", 32'(bus.req_ready), 32'd1);
        check("rstmid resp", 32'(bus.resp_valid), 32'd0);
        access("LWpostrst", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_mem_access.md
Name: lsu_mem_access

Overview:
- Load/store initiator between the pipeline MEM stage and the byte-addressed data memory. Accepts one load or store request at a time, decodes RV32I funct3 into byte mask and lane data, and drives the memory's address, write_data, write_enable and write_mask.
- Captures and sign/zero-extends load data, then returns a registered response with a fault flag.
- Memory write is synchronous; memory read is combinational.

Parameters:
- DMEM_BYTES, 4096, memory size in bytes; accesses with any byte at or beyond this address fault.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  system clock, posedge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and faults
- resp_fault  out  1  access rejected
- mem_address  out  32  to memory address
- mem_write_data  out  32  to memory write_data
- mem_write_enable  out  1  to memory write_enable
- mem_write_mask  out  4  to memory write_mask
- mem_read_data  in  32  from memory read_data

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; resp_valid=0, resp_rdata=0, resp_fault=0; mem_address=0, mem_write_data=0, mem_write_enable=0, mem_write_mask=0. req_ready=1 while in IDLE.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: req_ready=1. On req_valid, register we/funct3/addr/wdata and go to ACCESS.
  - ACCESS: req_ready=0. Drive the memory from the registered request.
    - Store, no fault: mem_write_enable=1 for exactly this cycle. Memory commits at the closing edge.
    - Load: mem_write_enable=0. The extended mem_read_data is captured into resp_rdata at the closing edge.
    - Fault: mem_write_enable=0 and mem_write_mask=0.
    - Always go to RESP.
  - RESP: resp_valid=1 for one cycle. req_ready=1; a request accepted here goes to ACCESS, otherwise go to IDLE.
- Latency: request accepted at edge N; memory access in cycle N+1; resp_valid in cycle N+2. Throughput is one access per 2 cycles. There is no response backpressure.
- Load decode: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
- Store decode: funct3 000 SB mask 0001, 001 SH mask 0011, 010 SW mask 1111. Store data is passed LSB-aligned (byte lane 0 lands at address).
- mem_address = registered addr during ACCESS and 0 otherwise; mem_write_data is likewise 0 outside ACCESS.
- Fault conditions:
  - Illegal funct3: load 011/110/111; store with funct3[2]=1 or 011.
  - Range: addr + size - 1 >= DMEM_BYTES, computed in 33 bits so that 0xFFFFFFFF does not wrap.
  - A faulting access issues no write, and the response has resp_fault=1 and resp_rdata=0.
- Reset mid-operation: a reset asserted during ACCESS drops mem_write_enable immediately; that store is not committed. No response is produced.
- req_valid while req_ready=0 is ignored. The requester holds the request.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]!=0, fault as above, with no memory write.
- Undefined: misaligned accesses are performed normally, since the memory is byte-addressed with per-byte lanes. Only range and illegal-funct3 faults apply.

Decomposition:
- Package lsu_pkg:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - state enum lsu_state_t {IDLE, ACCESS, RESP}.
  - size-from-funct3 function.
- Sub-module load_extend: combinational funct3 + raw 32-bit word -> extended 32-bit result. It is instantiated once in lsu_mem_access.

Test Plan:
- SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 -> mem_write_enable high exactly 1 cycle with mask 1111; load resp_rdata=0xDEADBEEF, resp_valid 2 cycles after accept.
- SB 0x20 wdata 0x000000F0 over prior word 0x11223344 at 0x20, then LB 0x20 -> 0xFFFFFFF0; LBU 0x20 -> 0x000000F0; LW 0x20 -> 0x112233F0.
- LH/LHU on halfword 0x8001 at 0x40 -> 0xFFFF8001 / 0x00008001.
- SW at 0xFFE (DMEM_BYTES=4096) -> resp_fault=1, no write pulse. LW 0xFFFFFFFF -> fault, no wrap. Load funct3 011 -> fault.
- Misaligned LW at 0x41 -> fault with LSU_MISALIGN_TRAP_EN; without it, returns bytes 0x41..0x44.
- Back-to-back: req_valid held high -> accepts in IDLE and RESP only; assert rst_n=0 during a store ACCESS -> write_enable drops immediately, memory unchanged, FSM in IDLE.
